// File: rtl/alu_pkg.sv
// Shared types for the ALU command engine: operation codes and engine states.
package alu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      OR  = 2'b11
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } eng_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: modulo add/sub with carry/borrow, bitwise and/or.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  alu_op_t          i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_diff;

   // The extra top bit carries out on add and becomes the borrow (a<b) on sub.
   assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
   assign w_diff = {1'b0, i_a} - {1'b0, i_b};

   always_comb begin
      o_result = '0;
      o_carry  = 1'b0;
      case (i_op)
         ADD: begin
            o_result = w_sum[WIDTH-1:0];
            o_carry  = w_sum[WIDTH];
         end
         SUB: begin
            o_result = w_diff[WIDTH-1:0];
            o_carry  = w_diff[WIDTH];
         end
         AND: o_result = i_a & i_b;
         OR:  o_result = i_a | i_b;
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_engine.sv
// Three-state (IDLE/EXEC/HOLD) command engine around alu_core with a consumed-response counter.
// Optional zero/carry flag outputs are enabled by defining ALU_CMD_FLAGS_EN.
module alu_cmd_engine
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
`ifdef ALU_CMD_FLAGS_EN
   output logic             rsp_zero,
   output logic             rsp_carry,
`endif
   output logic [CNT_W-1:0] op_count
);

   eng_state_t       r_state;
   alu_op_t          r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_rsp_data;
   logic             r_rsp_valid;
   logic             r_cmd_ready;
   logic [CNT_W-1:0] r_op_count;
   logic [WIDTH-1:0] w_result;
`ifdef ALU_CMD_FLAGS_EN
   logic             w_carry;
   logic             r_rsp_zero;
   logic             r_rsp_carry;
`else
   logic             w_unused_carry;
`endif

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_op     (r_op),
      .i_a      (r_a),
      .i_b      (r_b),
      .o_result (w_result),
`ifdef ALU_CMD_FLAGS_EN
      .o_carry  (w_carry)
`else
      .o_carry  (w_unused_carry)
`endif
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rsp_valid <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_rsp_data  <= '0;
         r_op_count  <= '0;
`ifdef ALU_CMD_FLAGS_EN
         r_rsp_zero  <= 1'b0;
         r_rsp_carry <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (cmd_valid) begin
                  r_op        <= alu_op_t'(cmd_op);
                  r_a         <= cmd_a;
                  r_b         <= cmd_b;
                  r_cmd_ready <= 1'b0;
                  r_state     <= EXEC;
               end
            end
            EXEC: begin
               r_rsp_data  <= w_result;
`ifdef ALU_CMD_FLAGS_EN
               r_rsp_zero  <= (w_result == '0);
               r_rsp_carry <= w_carry;
`endif
               r_rsp_valid <= 1'b1;
               r_state     <= HOLD;
            end
            HOLD: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_op_count  <= r_op_count + CNT_W'(1);
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   // Ready sits high through reset so it is live on the first cycle after release; the mask keeps it low while held.
   assign cmd_ready = r_cmd_ready & rst_n;
   assign rsp_valid = r_rsp_valid;
   assign rsp_data  = r_rsp_data;
   assign op_count  = r_op_count;
`ifdef ALU_CMD_FLAGS_EN
   assign rsp_zero  = r_rsp_zero;
   assign rsp_carry = r_rsp_carry;
`endif

endmodule

// File: tb/tb_alu_cmd_engine.sv
// Scoreboard bench for alu_cmd_engine: driver pushes expected responses, a negedge monitor pops and compares.
module tb_alu_cmd_engine;

   localparam int CNT_MOD = 16;

   typedef struct {
      logic [7:0] data;
      bit         carry;
      bit         zero;
      int         rise;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_a;
   logic [7:0] cmd_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [3:0] op_count;
`ifdef ALU_CMD_FLAGS_EN
   logic       rsp_zero;
   logic       rsp_carry;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   model_cnt = 0;
   bit   rand_mode = 0;
   exp_t exp_q[$];

   alu_cmd_engine #(
      .WIDTH (8),
      .CNT_W (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_a     (cmd_a),
      .cmd_b     (cmd_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
`ifdef ALU_CMD_FLAGS_EN
      .rsp_zero  (rsp_zero),
      .rsp_carry (rsp_carry),
`endif
      .op_count  (op_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
      end
   endtask

   function automatic exp_t ref_model(input int op, input int a, input int b);
      exp_t e;
      int   r;
      e.carry = 1'b0;
      e.rise  = 0;
      case (op)
         0: begin r = a + b; e.carry = (r > 255); r = r % 256; end
         1: begin r = a - b; e.carry = (a < b); if (r < 0) r = r + 256; end
         2: r = a & b;
         3: r = a | b;
         default: r = 0;
      endcase
      e.data = 8'(r);
      e.zero = (r == 0);
      return e;
   endfunction

   task automatic issue(input int op, input int a, input int b, input bit exp_rsp, output int acc);
      bit   seen = 0;
      int   g = 0;
      exp_t e;
      cmd_op    = 2'(op);
      cmd_a     = 8'(a);
      cmd_b     = 8'(b);
      cmd_valid = 1'b1;
      acc       = -1;
      while (!seen && g < 200) begin
         @(negedge clk);
         if (cmd_ready) begin
            seen = 1;
            acc  = cyc;
            if (exp_rsp) begin
               e = ref_model(op, a, b);
               e.rise = cyc + 2;
               exp_q.push_back(e);
            end
         end
         @(posedge clk); #1;
         if (rand_mode) rsp_ready = 1'($urandom_range(0, 1));
         g++;
      end
      cmd_valid = 1'b0;
      if (!seen) check("accept_timeout", 0, 1);
      $display("[TB] cmd op=%0d a=0x%02h b=0x%02h accepted_cycle=%0d", op, a, b, acc);
   endtask

   task automatic wait_drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 500) begin
         @(posedge clk); #1;
         if (rand_mode) rsp_ready = 1'($urandom_range(0, 1));
         g++;
      end
      if (g >= 500) check("drain_timeout", 1, 0);
      @(posedge clk); #1;
   endtask

   // Monitor / scoreboard
   initial begin
      bit   prev_v = 0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            model_cnt = 0;
            prev_v    = 0;
         end else begin
            if (rsp_valid) begin
               check("cmd_ready_in_hold", int'(cmd_ready), 0);
               if (exp_q.size() == 0) begin
                  check("spurious_rsp_valid", 1, 0);
               end else begin
                  e = exp_q[0];
                  if (!prev_v) check("rsp_latency_cycle", cyc, e.rise);
                  check("rsp_data", int'(rsp_data), int'(e.data));
`ifdef ALU_CMD_FLAGS_EN
                  check("rsp_zero", int'(rsp_zero), int'(e.zero));
                  check("rsp_carry", int'(rsp_carry), int'(e.carry));
`endif
                  if (rsp_ready) begin
                     check("op_count_before_consume", int'(op_count), model_cnt);
                     $display("[TB] rsp data=0x%02h expected=0x%02h op_count=%0d", rsp_data, e.data, op_count);
                     void'(exp_q.pop_front());
                     model_cnt = (model_cnt + 1) % CNT_MOD;
                  end
               end
            end
            prev_v = rsp_valid;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int c_cons;
      int dir_op[5] = '{0, 0, 1, 2, 3};
      int dir_a[5]  = '{8'h0F, 8'hFF, 8'h05, 8'hF0, 8'hF0};
      int dir_b[5]  = '{8'h01, 8'h02, 8'h05, 8'h3C, 8'h3C};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 8'h00; cmd_b = 8'h00; rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_cmd_ready", int'(cmd_ready), 0);
      check("reset_rsp_valid", int'(rsp_valid), 0);
      check("reset_rsp_data", int'(rsp_data), 0);
      check("reset_op_count", int'(op_count), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("ready_after_release", int'(cmd_ready), 1);

      // Directed vectors with an always-ready consumer
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         issue(dir_op[i], dir_a[i], dir_b[i], 1, acc);
         wait_drain();
         if (i == 0) check("op_count_after_first", int'(op_count), 1);
      end

      // Consumer stalls 10 cycles while a second command waits
      rsp_ready = 1'b0;
      issue(2, 8'h5A, 8'h0F, 1, acc);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_a = 8'h33; cmd_b = 8'h44;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_cmd_ready", int'(cmd_ready), 0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      c_cons = cyc;
      issue(0, 8'h33, 8'h44, 1, acc);
      check("accept_after_consume", acc, c_cons + 1);
      wait_drain();

      // Reset while the command is in EXEC
      issue(1, 8'h80, 8'h01, 0, acc);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("exec_reset_rsp_valid", int'(rsp_valid), 0);
      check("exec_reset_cmd_ready", int'(cmd_ready), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("exec_reset_ready_after", int'(cmd_ready), 1);
      check("exec_reset_op_count", int'(op_count), 0);
      check("exec_reset_no_rsp", int'(rsp_valid), 0);
      repeat (3) @(posedge clk);
      #1;

      // Counter wrap with a 4-bit counter
      for (int i = 0; i < 15; i++) begin
         issue($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 1, acc);
         wait_drain();
      end
      check("op_count_at_15", int'(op_count), 15);
      issue($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 1, acc);
      wait_drain();
      check("op_count_wrap", int'(op_count), 0);

      // Random traffic with a random consumer
      rand_mode = 1;
      for (int i = 0; i < 80; i++) begin
         issue($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255), 1, acc);
      end
      rand_mode = 0;
      rsp_ready = 1'b1;
      wait_drain();
      check("final_op_count", int'(op_count), model_cnt);
      check("final_queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
